// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants and the instruction queue entry type.
package riscv_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } q_entry_t;

endpackage

// File: rtl/instr_queue_if.sv
// Fetch-side and decode-side signals of the instruction queue.
interface instr_queue_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             flush;
  logic [1:0]       FetchValid;
  logic [31:0]      FetchInstr0;
  logic [31:0]      FetchInstr1;
  logic [31:0]      FetchPC;
  logic             FetchReady;
  logic             StallD;
  logic [31:0]      InstrD1;
  logic [31:0]      InstrD2;
  logic [31:0]      PCD1;
  logic [31:0]      PCD2;
  logic             ValidD1;
  logic             ValidD2;
  logic [CNT_W-1:0] Count;

  // Fetch/decode control side
  modport master (
    output flush, FetchValid, FetchInstr0, FetchInstr1, FetchPC, StallD,
    input  FetchReady, InstrD1, InstrD2, PCD1, PCD2, ValidD1, ValidD2, Count
  );

  // Queue side
  modport slave (
    input  flush, FetchValid, FetchInstr0, FetchInstr1, FetchPC, StallD,
    output FetchReady, InstrD1, InstrD2, PCD1, PCD2, ValidD1, ValidD2, Count
  );

endinterface

// File: rtl/pair_check.sv
// Intra-pair hazard check: H0 control flow or H0->H1 RAW blocks dual issue.
module pair_check
  import riscv_pkg::*;
(
  input  logic [31:0] h0,
  input  logic [31:0] h1,
  output logic        blocked
);

  logic [6:0] op0;
  logic [6:0] op1;
  logic [4:0] rd0;
  logic       ctrl0;
  logic       writes0;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       raw;
  logic       unused_bits;

  assign op0 = h0[6:0];
  assign op1 = h1[6:0];
  assign rd0 = h0[11:7];

  // Classify H0 and determine which source registers H1 reads
  always_comb begin
    ctrl0    = (op0 == OP_BRANCH) || (op0 == OP_JAL) || (op0 == OP_JALR);
    writes0  = (op0 != OP_BRANCH) && (op0 != OP_STORE) && (rd0 != 5'd0);
    uses_rs1 = !((op1 == OP_LUI) || (op1 == OP_AUIPC) || (op1 == OP_JAL));
    uses_rs2 = (op1 == OP_RTYPE) || (op1 == OP_STORE) || (op1 == OP_BRANCH);
    raw      = writes0 && ((uses_rs1 && (h1[19:15] == rd0)) ||
                           (uses_rs2 && (h1[24:20] == rd0)));
    blocked  = ctrl0 || raw;
  end

  assign unused_bits = ^{h0[31:12], h1[31:25], h1[14:7]};

endmodule

// File: rtl/instr_queue.sv
// Dual-issue instruction FIFO feeding the two IF/ID decode slot registers.
module instr_queue
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  instr_queue_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  q_entry_t         mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] push_n;
  logic [CNT_W-1:0] issue_n;
  q_entry_t         h0;
  q_entry_t         h1;
  logic             blocked;

  assign h0 = mem[rd_ptr];
  assign h1 = mem[rd_ptr + PTR_W'(1)];

  pair_check u_pair_check (
    .h0      (h0.instr),
    .h1      (h1.instr),
    .blocked (blocked)
  );

  assign bus.FetchReady = (CNT_W'(DEPTH) - count) >= CNT_W'(2);
  assign bus.Count      = count;

  // Push and issue counts for this cycle; flush suppresses both
  always_comb begin
    push_n  = '0;
    issue_n = '0;
    if (bus.FetchReady && !bus.flush) begin
      push_n = CNT_W'(bus.FetchValid[0]) + CNT_W'(bus.FetchValid[1]);
    end
    if (!bus.StallD && !bus.flush) begin
      if (count >= CNT_W'(2)) begin
        issue_n = blocked ? CNT_W'(1) : CNT_W'(2);
      end else begin
        issue_n = count;
      end
    end
  end

  // Storage write of one or two fetched instructions
  always_ff @(posedge clk) begin
    if (push_n != '0) begin
      mem[wr_ptr] <= '{instr: bus.FetchInstr0, pc: bus.FetchPC};
      if (bus.FetchValid[1]) begin
        mem[wr_ptr + PTR_W'(1)] <= '{instr: bus.FetchInstr1, pc: bus.FetchPC + 32'd4};
      end
    end
  end

  // Pointers and occupancy counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push_n);
      rd_ptr <= rd_ptr + PTR_W'(issue_n);
      count  <= count + push_n - issue_n;
    end
  end

  // Decode slot registers; hold while decode is stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.InstrD1 <= NOP_INSTR;
      bus.InstrD2 <= NOP_INSTR;
      bus.PCD1    <= '0;
      bus.PCD2    <= '0;
      bus.ValidD1 <= 1'b0;
      bus.ValidD2 <= 1'b0;
    end else if (bus.flush) begin
      bus.InstrD1 <= NOP_INSTR;
      bus.InstrD2 <= NOP_INSTR;
      bus.PCD1    <= '0;
      bus.PCD2    <= '0;
      bus.ValidD1 <= 1'b0;
      bus.ValidD2 <= 1'b0;
    end else if (!bus.StallD) begin
      if (issue_n >= CNT_W'(1)) begin
        bus.InstrD1 <= h0.instr;
        bus.PCD1    <= h0.pc;
        bus.ValidD1 <= 1'b1;
      end else begin
        bus.InstrD1 <= NOP_INSTR;
        bus.PCD1    <= '0;
        bus.ValidD1 <= 1'b0;
      end
      if (issue_n == CNT_W'(2)) begin
        bus.InstrD2 <= h1.instr;
        bus.PCD2    <= h1.pc;
        bus.ValidD2 <= 1'b1;
      end else begin
        bus.InstrD2 <= NOP_INSTR;
        bus.PCD2    <= '0;
        bus.ValidD2 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for the dual-issue instruction queue.
module tb_instr_queue;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_queue_if #(.DEPTH(8)) bus ();
  instr_queue #(.DEPTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;
  q_entry_t sb[$];

  localparam logic [31:0] ADD_X6_X5_X5 = 32'h0052_8333;
  localparam logic [31:0] BEQ_X0_X0_8  = 32'h0000_0463;
  localparam logic [31:0] ADD_X3_X0_X0 = 32'h0000_01B3;

  function automatic logic [31:0] addi(input int rd, input int imm);
    return {12'(imm), 5'd0, 3'd0, 5'(rd), 7'b0010011};
  endfunction

  // Advance one edge; if slots were allowed to load, compare them against the scoreboard
  task automatic tick();
    logic sd, fl;
    q_entry_t e;
    sd = bus.StallD;
    fl = bus.flush;
    @(posedge clk);
    #1;
    if (!sd && !fl && !rst) begin
      if (bus.ValidD1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_d1 unexpected instr=%h pc=%h", bus.InstrD1, bus.PCD1);
        end else begin
          e = sb.pop_front();
          if ({bus.InstrD1, bus.PCD1} !== {e.instr, e.pc}) begin
            errors++;
            $display("FAIL sb_d1 got=%h/%h exp=%h/%h", bus.InstrD1, bus.PCD1, e.instr, e.pc);
          end
        end
      end
      if (bus.ValidD2) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_d2 unexpected instr=%h pc=%h", bus.InstrD2, bus.PCD2);
        end else begin
          e = sb.pop_front();
          if ({bus.InstrD2, bus.PCD2} !== {e.instr, e.pc}) begin
            errors++;
            $display("FAIL sb_d2 got=%h/%h exp=%h/%h", bus.InstrD2, bus.PCD2, e.instr, e.pc);
          end
        end
      end else begin
        checks++;
        if ({bus.InstrD2, bus.PCD2} !== {NOP_INSTR, 32'h0}) begin
          errors++;
          $display("FAIL d2_invalid_nop got=%h/%h exp=%h/0", bus.InstrD2, bus.PCD2, NOP_INSTR);
        end
      end
    end
  endtask

  task automatic push_pair(input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] pc);
    bus.FetchValid  = 2'b11;
    bus.FetchInstr0 = i0;
    bus.FetchInstr1 = i1;
    bus.FetchPC     = pc;
    sb.push_back('{instr: i0, pc: pc});
    sb.push_back('{instr: i1, pc: pc + 32'd4});
    tick();
    bus.FetchValid = 2'b00;
  endtask

  task automatic test_reset();
    bus.flush = 0; bus.FetchValid = 0; bus.FetchInstr0 = 0; bus.FetchInstr1 = 0;
    bus.FetchPC = 0; bus.StallD = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.Count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.Count); end
    checks++; if (bus.FetchReady !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.FetchReady); end
    checks++; if ({bus.ValidD1, bus.ValidD2} !== 2'b00) begin errors++; $display("FAIL reset_valid got=%b exp=00", {bus.ValidD1, bus.ValidD2}); end
    checks++; if ({bus.InstrD1, bus.InstrD2} !== {NOP_INSTR, NOP_INSTR}) begin errors++; $display("FAIL reset_instr got=%h %h exp=nop", bus.InstrD1, bus.InstrD2); end
    checks++; if ({bus.PCD1, bus.PCD2} !== 64'h0) begin errors++; $display("FAIL reset_pc got=%h %h exp=0", bus.PCD1, bus.PCD2); end
    rst = 0;
  endtask

  task automatic test_dual();
    push_pair(addi(1, 1), addi(2, 2), 32'h0);
    checks++; if (bus.Count !== 4'd2) begin errors++; $display("FAIL dual_count_after_push got=%0d exp=2", bus.Count); end
    checks++; if (bus.ValidD1 !== 1'b0) begin errors++; $display("FAIL dual_no_bypass got=%b exp=0", bus.ValidD1); end
    tick();
    checks++; if ({bus.ValidD1, bus.ValidD2} !== 2'b11) begin errors++; $display("FAIL dual_valid got=%b exp=11", {bus.ValidD1, bus.ValidD2}); end
    checks++; if ({bus.PCD1, bus.PCD2} !== {32'h0, 32'h4}) begin errors++; $display("FAIL dual_pc got=%h %h exp=0 4", bus.PCD1, bus.PCD2); end
    checks++; if (bus.Count !== 4'd0) begin errors++; $display("FAIL dual_count got=%0d exp=0", bus.Count); end
  endtask

  task automatic test_raw();
    push_pair(addi(5, 1), ADD_X6_X5_X5, 32'h100);
    tick();
    checks++; if ({bus.ValidD1, bus.ValidD2} !== 2'b10) begin errors++; $display("FAIL raw_split got=%b exp=10", {bus.ValidD1, bus.ValidD2}); end
    checks++; if (bus.Count !== 4'd1) begin errors++; $display("FAIL raw_count got=%0d exp=1", bus.Count); end
    tick();
    checks++; if ({bus.ValidD1, bus.ValidD2, bus.PCD1} !== {2'b10, 32'h104}) begin errors++; $display("FAIL raw_second got=%b%b pc=%h exp=10 pc=104", bus.ValidD1, bus.ValidD2, bus.PCD1); end
    tick();
    checks++; if (bus.ValidD1 !== 1'b0) begin errors++; $display("FAIL raw_empty got=%b exp=0", bus.ValidD1); end
  endtask

  task automatic test_branch();
    push_pair(BEQ_X0_X0_8, addi(1, 1), 32'h200);
    tick();
    checks++; if ({bus.ValidD1, bus.ValidD2, bus.PCD1} !== {2'b10, 32'h200}) begin errors++; $display("FAIL branch_alone got=%b%b pc=%h exp=10 pc=200", bus.ValidD1, bus.ValidD2, bus.PCD1); end
    tick();
    push_pair(addi(0, 1), ADD_X3_X0_X0, 32'h300);
    tick();
    checks++; if ({bus.ValidD1, bus.ValidD2, bus.PCD2} !== {2'b11, 32'h304}) begin errors++; $display("FAIL rd_x0_dual got=%b%b pc2=%h exp=11 pc2=304", bus.ValidD1, bus.ValidD2, bus.PCD2); end
  endtask

  task automatic test_stall_wrap();
    logic [31:0] single;
    single = addi(7, 7);
    bus.FetchValid = 2'b01; bus.FetchInstr0 = single; bus.FetchPC = 32'h3F0;
    sb.push_back('{instr: single, pc: 32'h3F0});
    tick();
    bus.FetchValid = 2'b00;
    tick();
    bus.StallD = 1;
    for (int k = 0; k < 4; k++) begin
      push_pair(addi(2 * k + 1, k), addi(2 * k + 2, k), 32'h400 + 32'(8 * k));
    end
    checks++; if (bus.Count !== 4'd8) begin errors++; $display("FAIL stall_count got=%0d exp=8", bus.Count); end
    checks++; if (bus.FetchReady !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", bus.FetchReady); end
    checks++; if ({bus.ValidD1, bus.InstrD1, bus.PCD1} !== {1'b1, single, 32'h3F0}) begin errors++; $display("FAIL stall_hold got=%b %h %h exp=1 %h 3f0", bus.ValidD1, bus.InstrD1, bus.PCD1, single); end
    bus.FetchValid = 2'b11; bus.FetchInstr0 = 32'hDEAD_0013; bus.FetchInstr1 = 32'hBEEF_0013; bus.FetchPC = 32'h900;
    tick();
    bus.FetchValid = 2'b00;
    checks++; if (bus.Count !== 4'd8) begin errors++; $display("FAIL full_no_push got=%0d exp=8", bus.Count); end
    bus.StallD = 0;
    repeat (4) tick();
    checks++; if (bus.Count !== 4'd0) begin errors++; $display("FAIL wrap_drain got=%0d exp=0", bus.Count); end
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL wrap_sb_left got=%0d exp=0", sb.size()); end
    tick();
  endtask

  task automatic test_flush();
    bus.StallD = 1;
    for (int k = 0; k < 3; k++) begin
      push_pair(addi(k + 1, 3), addi(k + 4, 3), 32'h500 + 32'(8 * k));
    end
    checks++; if (bus.Count !== 4'd6) begin errors++; $display("FAIL flush_pre_count got=%0d exp=6", bus.Count); end
    bus.flush = 1;
    bus.FetchValid = 2'b11; bus.FetchInstr0 = addi(9, 9); bus.FetchInstr1 = addi(10, 10); bus.FetchPC = 32'h5F0;
    tick();
    sb.delete();
    bus.flush = 0; bus.FetchValid = 2'b00; bus.StallD = 0;
    checks++; if (bus.Count !== 4'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", bus.Count); end
    checks++; if ({bus.ValidD1, bus.ValidD2} !== 2'b00) begin errors++; $display("FAIL flush_valid got=%b exp=00", {bus.ValidD1, bus.ValidD2}); end
    repeat (2) tick();
    checks++; if ({bus.ValidD1, bus.Count} !== 5'd0) begin errors++; $display("FAIL flush_push_dropped got=%b cnt=%0d exp=0 cnt=0", bus.ValidD1, bus.Count); end
  endtask

  task automatic test_async_reset();
    push_pair(addi(1, 6), addi(2, 6), 32'h600);
    push_pair(addi(3, 6), addi(4, 6), 32'h608);
    checks++; if ({bus.ValidD1, bus.Count} !== {1'b1, 4'd2}) begin errors++; $display("FAIL pre_reset got=%b cnt=%0d exp=1 cnt=2", bus.ValidD1, bus.Count); end
    #2;
    rst = 1;
    #1;
    checks++; if ({bus.ValidD1, bus.ValidD2} !== 2'b00) begin errors++; $display("FAIL async_valid got=%b exp=00", {bus.ValidD1, bus.ValidD2}); end
    checks++; if ({bus.InstrD1, bus.PCD1} !== {NOP_INSTR, 32'h0}) begin errors++; $display("FAIL async_slot got=%h %h exp=nop 0", bus.InstrD1, bus.PCD1); end
    checks++; if ({bus.Count, bus.FetchReady} !== {4'd0, 1'b1}) begin errors++; $display("FAIL async_count got=%0d rdy=%b exp=0 rdy=1", bus.Count, bus.FetchReady); end
    sb.delete();
    #1;
    rst = 0;
    tick();
    checks++; if (bus.ValidD1 !== 1'b0) begin errors++; $display("FAIL post_reset_idle got=%b exp=0", bus.ValidD1); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) begin
      push_pair(addi(k + 10, k), addi(k + 20, k), 32'h700 + 32'(8 * k));
      if (k > 0) begin
        checks++; if ({bus.ValidD1, bus.ValidD2, bus.Count} !== {2'b11, 4'd2}) begin errors++; $display("FAIL b2b_%0d got=%b%b cnt=%0d exp=11 cnt=2", k, bus.ValidD1, bus.ValidD2, bus.Count); end
      end
    end
    tick();
    checks++; if (bus.Count !== 4'd0) begin errors++; $display("FAIL b2b_drain got=%0d exp=0", bus.Count); end
    tick();
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL b2b_sb_left got=%0d exp=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_dual();
    test_raw();
    test_branch();
    test_stall_wrap();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_queue.md
# instr_queue

Dual-issue instruction queue and IF/ID pipeline register between instruction fetch and the dual-slot decode stage. Accepts up to two instructions per cycle from fetch and buffers them in a circular FIFO. Each cycle it registers zero, one or two in-order instructions into decode slots 1 (older) and 2 (younger). Only pairs passing the intra-pair hazard check are issued together.

## Interface
- DEPTH, 8, number of 32-bit entries; power of two, ≥ 4
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  discard all queued and registered instructions (redirect)
- FetchValid  in  2  bit0 = FetchInstr0 valid, bit1 = FetchInstr1 valid; bit1 without bit0 is illegal
- FetchInstr0  in  32  older fetched instruction
- FetchInstr1  in  32  younger fetched instruction (PC = FetchPC + 4)
- FetchPC  in  32  PC of FetchInstr0
- FetchReady  out  1  ≥ 2 free entries; a push occurs only when FetchReady is high
- StallD  in  1  decode stalled: hold slot outputs, no pop
- InstrD1, InstrD2  out  32  slot instructions to decode
- PCD1, PCD2  out  32  slot PCs
- ValidD1, ValidD2  out  1  slot holds a real instruction
- Count  out  $clog2(DEPTH)+1  queued entries, excluding slot registers

## Operation
- Storage: DEPTH entries of {instr[31:0], pc[31:0]}; read pointer and write pointer of $clog2(DEPTH) bits each, wrapping modulo DEPTH; separate occupancy counter.
- Push, when FetchReady && FetchValid != 0:
  - Write FetchInstr0/FetchPC at wr_ptr.
  - If bit1 is set, also write FetchInstr1/FetchPC+4 at wr_ptr+1.
  - wr_ptr and count advance by popcount(FetchValid).
- Issue decision (combinational, on head H0/H1), when !StallD && !flush:
  - count = 0: issue 0.
  - count = 1: issue H0 only.
  - count ≥ 2: issue both unless the pair is blocked, in which case issue H0 only.
- Pair blocked when either holds:
  - H0 opcode is branch (1100011), JAL (1101111) or JALR (1100111).
  - RAW: H0 writes rd (opcode not branch/store), rd != x0, and H1 uses rs1 or rs2 equal to rd. rs1 is used unless H1 is LUI/AUIPC/JAL; rs2 is used only by R-type, store and branch.
- Slot load, on each edge with !StallD: D1 = H0 if issue ≥ 1, else NOP 0x00000013 with Valid 0; D2 = H1 if issue = 2, else NOP with Valid 0. Invalid slots carry PC 0.
- Pop: rd_ptr and count advance by the issue count.
- Simultaneous push and pop: count_next = count + pushed − issued. An entry pushed this cycle is never issued in the same cycle.
- StallD: slot registers hold, no pop; push still allowed while FetchReady.
- flush, which overrides push, pop and StallD:
  - Next edge sets pointers and count to 0 and slots to NOP/invalid.
  - Fetch data presented in the flush cycle is dropped.
- FetchReady = (DEPTH − count) ≥ 2, computed from registered count.
- Full: at count = DEPTH−1 or DEPTH, FetchReady is low; no overwrite is possible.

## Timing
- Reset (asynchronous): count 0, pointers 0, FetchReady 1, InstrD1/D2 = 0x00000013, PCD1/PCD2 = 0, ValidD1/D2 = 0.
- Latency: an instruction pushed at edge N appears on InstrD1/D2 at the earliest after edge N+1. There is no fetch-to-slot bypass.
- Throughput: 2 instructions/cycle sustained with unblocked pairs and no stall.
- All outputs are registered except FetchReady, which is a combinational compare of the count register.
- Reset mid-operation clears everything immediately; the first push after rst deasserts follows the normal rules.

## Structure
- Shared package riscv_pkg:
  - Opcode constants OP_BRANCH, OP_JAL, OP_JALR, OP_STORE, OP_LUI, OP_AUIPC, OP_RTYPE.
  - NOP_INSTR = 32'h00000013.
  - Queue entry struct type.
- One combinational sub-module, pair_check: inputs H0, H1; output blocked. It holds the RAW and control-flow rules so they can be reused by verification.
- Top level holds the storage array, pointers, counter and slot registers.

## Test plan
- Reset, then push {addi x1,x0,1 / addi x2,x0,2} at PC 0x0 → after 2 edges: ValidD1 = ValidD2 = 1, PCD1 = 0x0, PCD2 = 0x4, Count = 0.
- Push {addi x5,x0,1 / add x6,x5,x5} → D1 = addi, D2 = NOP with ValidD2 = 0; add issues in D1 on the next edge.
- Push {beq x0,x0,8 / addi x1,x0,1} → beq issues alone; a pair with rd = x0 in H0 (addi x0,x0,1 then add x3,x0,x0) issues dual.
- Hold StallD = 1 and push four pairs with DEPTH = 8 → Count reaches 7 or 8, FetchReady drops, slots hold their values; release StallD → order preserved across pointer wrap.
- Assert flush with Count = 6 and a simultaneous push → next edge: Count = 0, ValidD1 = ValidD2 = 0, pushed data absent.
- Assert rst asynchronously mid-stream (between edges) → outputs take their reset values immediately, without waiting for a clock edge.
